// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-fetch sequencer.
// The FIFO entry pairs each fetched word with the address it was read from.
package fetch_pkg;

    localparam int unsigned WIDTH_DEF     = 9;
    localparam int unsigned DEPTH_DEF     = 32;
    localparam int unsigned ADDR_BITS_DEF = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH_DEF-1:0]     instr;
        logic [ADDR_BITS_DEF-1:0] pc;
    } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO buffering fetched words for decode.
// Flush takes priority over push; a pop and a push may share a cycle even when full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fifo_entry_t
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entry_t     din,
    output entry_t     head,
    output logic [1:0] count
);

    entry_t     mem_q [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && !flush && ((count_q != 2'd2) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (do_push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle synchronous instruction ROM: owns the PC, hides the
// read latency behind a 2-entry buffer and hands words to decode over valid/ready.
module rom_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
    parameter int unsigned START_ADDR = 0
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 START,
    input  logic                 HALT,
    input  logic                 REDIRECT,
    input  logic [ADDR_BITS-1:0] REDIRECT_ADDR,
    output logic [ADDR_BITS-1:0] ROM_ADDR,
    input  logic [WIDTH-1:0]     ROM_DATA,
    output logic [WIDTH-1:0]     INSTR,
    output logic [ADDR_BITS-1:0] INSTR_PC,
    output logic                 INSTR_VALID,
    input  logic                 INSTR_READY,
    output logic                 BUSY,
    output logic                 ERR
);

    typedef struct packed {
        logic [WIDTH-1:0]     instr;
        logic [ADDR_BITS-1:0] pc;
    } fetch_entry_t;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] pc_q, pc_d;
    logic                 inflight_q, inflight_d;
    logic [ADDR_BITS-1:0] inflight_pc_q;
    logic                 err_q, err_d;

    logic                 redir_ok, redir_bad;
    logic                 pop, push, issue;
    logic [2:0]           occupancy;
    logic [1:0]           fifo_count;
    fetch_entry_t         fifo_din, fifo_head;

    assign redir_ok  = REDIRECT && (32'(REDIRECT_ADDR) < DEPTH);
    assign redir_bad = REDIRECT && !redir_ok;

    assign INSTR_VALID = (fifo_count != 2'd0);
    assign pop         = INSTR_VALID && INSTR_READY;

    // A word still in flight when a redirect arrives belongs to the old stream.
    assign push     = inflight_q && !REDIRECT;
    assign fifo_din = '{instr: ROM_DATA, pc: inflight_pc_q};

    // Only issue when the word will have a buffer slot by the time it returns.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign issue     = (state_q == RUN) && !HALT && !REDIRECT
                       && (occupancy <= (3'd1 + {2'b00, pop}));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = issue;
        err_d      = err_q | redir_bad;

        unique case (state_q)
            IDLE:    if (START && !HALT) state_d = RUN;
            RUN:     if (HALT) state_d = HALTED;
            HALTED:  if (START && !HALT) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (redir_bad) begin
            state_d = HALTED;
        end

        if (redir_ok) begin
            pc_d = REDIRECT_ADDR;
        end else if (issue) begin
            pc_d = (32'(pc_q) == DEPTH - 1) ? '0 : pc_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q       <= IDLE;
            pc_q          <= ADDR_BITS'(START_ADDR);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    fetch_fifo #(
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .CLK    (CLK),
        .RESETN (RESETN),
        .push   (push),
        .pop    (pop),
        .flush  (REDIRECT),
        .din    (fifo_din),
        .head   (fifo_head),
        .count  (fifo_count)
    );

    assign ROM_ADDR = pc_q;
    assign INSTR    = INSTR_VALID ? fifo_head.instr : '0;
    assign INSTR_PC = INSTR_VALID ? fifo_head.pc : '0;
    assign BUSY     = (state_q == RUN) || inflight_q || INSTR_VALID;
    assign ERR      = err_q;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl: three instances cover the default map,
// a start address near the top of the ROM, and a ROM shallower than its address space.
module tb_rom_fetch_ctrl;

    logic CLK = 1'b0;
    logic RESETN;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // dut0: default instance
    logic       start0, halt0, redir0, ready0;
    logic [4:0] raddr0, rom_addr0, ipc0;
    logic [8:0] rom_data0, instr0;
    logic       ival0, busy0, err0;

    // dut1: START_ADDR = 30
    logic       start1;
    logic [4:0] rom_addr1, ipc1;
    logic [8:0] rom_data1, instr1;
    logic       ival1, busy1, err1;

    // dut2: DEPTH = 24
    logic       start2, redir2;
    logic [4:0] raddr2, rom_addr2, ipc2;
    logic [8:0] rom_data2, instr2;
    logic       ival2, busy2, err2;

    logic       zero = 1'b0;
    logic       one  = 1'b1;
    logic [4:0] zaddr = 5'd0;

    always_ff @(posedge CLK) begin
        rom_data0 <= 9'h100 + 9'(rom_addr0);
        rom_data1 <= 9'h100 + 9'(rom_addr1);
        rom_data2 <= 9'h100 + 9'(rom_addr2);
    end

    rom_fetch_ctrl u_dut0 (
        .CLK (CLK), .RESETN (RESETN), .START (start0), .HALT (halt0),
        .REDIRECT (redir0), .REDIRECT_ADDR (raddr0), .ROM_ADDR (rom_addr0),
        .ROM_DATA (rom_data0), .INSTR (instr0), .INSTR_PC (ipc0),
        .INSTR_VALID (ival0), .INSTR_READY (ready0), .BUSY (busy0), .ERR (err0)
    );

    rom_fetch_ctrl #(.START_ADDR (30)) u_dut1 (
        .CLK (CLK), .RESETN (RESETN), .START (start1), .HALT (zero),
        .REDIRECT (zero), .REDIRECT_ADDR (zaddr), .ROM_ADDR (rom_addr1),
        .ROM_DATA (rom_data1), .INSTR (instr1), .INSTR_PC (ipc1),
        .INSTR_VALID (ival1), .INSTR_READY (one), .BUSY (busy1), .ERR (err1)
    );

    rom_fetch_ctrl #(.DEPTH (24)) u_dut2 (
        .CLK (CLK), .RESETN (RESETN), .START (start2), .HALT (zero),
        .REDIRECT (redir2), .REDIRECT_ADDR (raddr2), .ROM_ADDR (rom_addr2),
        .ROM_DATA (rom_data2), .INSTR (instr2), .INSTR_PC (ipc2),
        .INSTR_VALID (ival2), .INSTR_READY (one), .BUSY (busy2), .ERR (err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int exp_pc;
        logic [4:0] wrap_pc [4];
        wrap_pc[0] = 5'd30; wrap_pc[1] = 5'd31; wrap_pc[2] = 5'd0; wrap_pc[3] = 5'd1;

        start0 = 0; halt0 = 0; redir0 = 0; raddr0 = 0; ready0 = 1;
        start1 = 0; start2 = 0; redir2 = 0; raddr2 = 0;
        RESETN = 1'b1;
        #2 RESETN = 1'b0;
        #1;
        check("rst_rom_addr", rom_addr0, 0);
        check("rst_instr", instr0, 0);
        check("rst_instr_pc", ipc0, 0);
        check("rst_valid", ival0, 0);
        check("rst_busy", busy0, 0);
        check("rst_err", err0, 0);
        check("rst_rom_addr_start30", rom_addr1, 30);
        tick();
        RESETN = 1'b1;
        tick();

        // Full-rate fetch: START in cycle 0, first valid in cycle 3
        start0 = 1;
        tick();
        start0 = 0;
        check("lat_c1_valid", ival0, 0);
        check("lat_c1_rom_addr", rom_addr0, 0);
        check("lat_c1_busy", busy0, 1);
        tick();
        check("lat_c2_valid", ival0, 0);
        tick();
        check("lat_c3_valid", ival0, 1);
        check("lat_c3_instr", instr0, 9'h100);
        check("lat_c3_pc", ipc0, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("stream_valid", ival0, 1);
            check("stream_pc", ipc0, k);
            check("stream_instr", instr0, 9'h100 + k);
        end

        // Backpressure: head stays at PC 3, two words buffered, ROM_ADDR frozen at 5
        ready0 = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", ival0, 1);
            check("bp_pc", ipc0, 3);
            check("bp_rom_addr", rom_addr0, 5);
        end
        ready0 = 1;
        exp_pc = 4;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("bp_resume_valid", ival0, 1);
            check("bp_resume_pc", ipc0, exp_pc);
            check("bp_resume_instr", instr0, 9'h100 + exp_pc);
            check("bp_resume_rom_addr", rom_addr0, exp_pc + 2);
            exp_pc++;
        end

        // Redirect with PC 9 presented, PC 10 in flight
        redir0 = 1; raddr0 = 5'd7;
        tick();
        redir0 = 0;
        check("redir_c1_valid", ival0, 0);
        check("redir_c1_rom_addr", rom_addr0, 7);
        check("redir_c1_busy", busy0, 1);
        tick();
        check("redir_c2_valid", ival0, 0);
        tick();
        check("redir_first_valid", ival0, 1);
        check("redir_first_pc", ipc0, 7);
        check("redir_first_instr", instr0, 9'h107);
        tick();
        check("redir_next_pc", ipc0, 8);
        check("redir_next_instr", instr0, 9'h108);

        // Halt: in-flight PC 9 still delivered, then drain to idle
        halt0 = 1;
        tick();
        check("halt_drain_valid", ival0, 1);
        check("halt_drain_pc", ipc0, 9);
        check("halt_drain_busy", busy0, 1);
        tick();
        check("halt_empty_valid", ival0, 0);
        check("halt_busy", busy0, 0);
        check("halt_rom_addr", rom_addr0, 10);
        halt0 = 0; start0 = 1;
        tick();
        start0 = 0;
        tick();
        tick();
        check("resume_valid", ival0, 1);
        check("resume_pc", ipc0, 10);
        check("resume_instr", instr0, 9'h10A);

        // Asynchronous reset mid-run, observed before any clock edge
        #2 RESETN = 1'b0;
        #1;
        check("async_rst_valid", ival0, 0);
        check("async_rst_rom_addr", rom_addr0, 0);
        check("async_rst_busy", busy0, 0);
        tick();
        RESETN = 1'b1;
        tick();

        // Wrap-around from START_ADDR = 30
        start1 = 1;
        tick();
        start1 = 0;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("wrap_valid", ival1, 1);
            check("wrap_pc", ipc1, wrap_pc[k]);
            check("wrap_instr", instr1, 9'h100 + wrap_pc[k]);
        end

        // Out-of-range redirect on a 24-deep ROM
        start2 = 1;
        tick();
        start2 = 0;
        tick();
        tick();
        check("err_pre_valid", ival2, 1);
        check("err_pre_pc", ipc2, 0);
        check("err_pre_err", err2, 0);
        redir2 = 1; raddr2 = 5'd28;
        tick();
        redir2 = 0;
        check("err_flag", err2, 1);
        check("err_valid", ival2, 0);
        check("err_rom_addr", rom_addr2, 2);
        check("err_busy", busy2, 0);
        tick();
        tick();
        check("err_later_valid", ival2, 0);
        check("err_later_rom_addr", rom_addr2, 2);
        check("err_sticky", err2, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
